// File: rtl/sram_param_if.sv
// Request/response bundle for sram_param: requests from master, ready/read data from slave.
interface sram_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
);
  logic              cs;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic              inj_par_err;
  logic              req_ready;
  logic              busy;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;
  logic              par_err;

  modport master (
    output cs, wr, addr, data_in, inj_par_err,
    input  req_ready, busy, data_out, rd_valid, par_err
  );

  modport slave (
    input  cs, wr, addr, data_in, inj_par_err,
    output req_ready, busy, data_out, rd_valid, par_err
  );
endinterface

// File: rtl/sram_param.sv
// Single-port SRAM that zero-fills itself after reset, then serves one read or write per cycle.
// Optional per-word even parity is enabled by defining SRAM_PARITY_EN.
//
// state    | meaning
// ST_CLEAR | zero one word per cycle from address 0 to DEPTH-1; requests refused
// ST_RUN   | serve requests; left only through rst
module sram_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input logic          clk,
  input logic          rst,
  sram_param_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;
`ifdef SRAM_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              rd_valid_q, rd_valid_d;
  logic              par_err_q, par_err_d;
  logic [WORD_W-1:0] mem_q [DEPTH];

  logic              clearing;
  logic              acc_wr;
  logic              acc_rd;
  logic [WORD_W-1:0] wr_word;
  logic [WORD_W-1:0] rd_word;

  assign clearing = (state_q == ST_CLEAR);
  // Nothing is accepted on a reset edge, whatever state the FSM is leaving.
  assign acc_wr   = bus.cs & bus.wr  & ~clearing & ~rst;
  assign acc_rd   = bus.cs & ~bus.wr & ~clearing & ~rst;
  assign rd_word  = mem_q[bus.addr];

`ifdef SRAM_PARITY_EN
  assign wr_word = {(^bus.data_in) ^ bus.inj_par_err, bus.data_in};
`else
  logic unused_inj;
  assign unused_inj = bus.inj_par_err;
  assign wr_word    = bus.data_in;
`endif

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    data_out_d = data_out_q;
    rd_valid_d = 1'b0;
    par_err_d  = 1'b0;
    if (clearing) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == '1) begin
        state_d = ST_RUN;
      end
    end
    if (acc_rd) begin
      data_out_d = rd_word[DATA_W-1:0];
      rd_valid_d = 1'b1;
`ifdef SRAM_PARITY_EN
      par_err_d  = ^rd_word;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      clr_cnt_q  <= '0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      par_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
      par_err_q  <= par_err_d;
    end
  end

  // All-zero is a valid even-parity word, so the clear needs no parity term.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clearing) begin
        mem_q[clr_cnt_q] <= '0;
      end else if (acc_wr) begin
        mem_q[bus.addr] <= wr_word;
      end
    end
  end

  assign bus.busy      = clearing;
  assign bus.req_ready = ~clearing;
  assign bus.data_out  = data_out_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.par_err   = par_err_q;
endmodule

// File: tb/tb_sram_param.sv
// Randomized bench for sram_param against an array-based model of the memory and its clear window.
module tb_sram_param;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  sram_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  sram_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] m_mem [DEPTH];
  bit                m_par [DEPTH];
  int                m_left = DEPTH;
  logic [DATA_W-1:0] m_dout = '0;
  bit                m_rv = 1'b0;
  bit                m_pe = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive, update the model with what the edge should do, then compare 1 time unit later.
  task automatic cyc(input bit r, input bit c, input bit w,
                     input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input bit inj);
    rst             = r;
    bus.cs          = c;
    bus.wr          = w;
    bus.addr        = a;
    bus.data_in     = d;
    bus.inj_par_err = inj;
    @(posedge clk);
    m_rv = 1'b0;
    m_pe = 1'b0;
    if (r) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[i] = '0;
        m_par[i] = 1'b0;
      end
      m_left = DEPTH;
      m_dout = '0;
    end else if (m_left > 0) begin
      m_left--;
    end else if (c && w) begin
      m_mem[a] = d;
      m_par[a] = inj;
    end else if (c) begin
      m_dout = m_mem[a];
      m_rv   = 1'b1;
`ifdef SRAM_PARITY_EN
      m_pe   = m_par[a];
`endif
    end
    #1;
    chk("busy",      32'(bus.busy),      32'(m_left > 0));
    chk("req_ready", 32'(bus.req_ready), 32'(m_left == 0));
    chk("rd_valid",  32'(bus.rd_valid),  32'(m_rv));
    chk("data_out",  32'(bus.data_out),  32'(m_dout));
    chk("par_err",   32'(bus.par_err),   32'(m_pe));
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic wr_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input bit inj);
    cyc(1'b0, 1'b1, 1'b1, a, d, inj);
  endtask

  task automatic rd_word(input logic [ADDR_W-1:0] a);
    cyc(1'b0, 1'b1, 1'b0, a, '0, 1'b0);
  endtask

  // Counts busy cycles after reset release; a stray write is attempted partway through.
  task automatic wait_clear();
    int n = 0;
    while (bus.busy === 1'b1 && n < 2 * DEPTH) begin
      cyc(1'b0, (n == 7), 1'b1, 10'h005, 8'hAA, 1'b0);
      n++;
    end
    chk("clear_len", 32'(n), 32'(DEPTH));
  endtask

  initial begin
    bus.cs = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.data_in = '0; bus.inj_par_err = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 10'h005, 8'h77, 1'b0);
    chk("rst_busy", 32'(bus.busy), 32'd1);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    wait_clear();

    rd_word(10'h005);
    chk("blocked_wr", 32'(bus.data_out), 32'h00);

    wr_word(10'h030, 8'hFC, 1'b0);
    rd_word(10'h030);
    chk("raw_data", 32'(bus.data_out), 32'hFC);
    chk("raw_valid", 32'(bus.rd_valid), 32'd1);
    rd_word(10'h03C);
    chk("cleared", 32'(bus.data_out), 32'h00);

    wr_word(10'h001, 8'h11, 1'b0);
    wr_word(10'h002, 8'h22, 1'b0);
    wr_word(10'h003, 8'h33, 1'b0);
    rd_word(10'h001);
    rd_word(10'h002);
    rd_word(10'h003);
    chk("b2b_last", 32'(bus.data_out), 32'h33);
    idle();
    chk("hold_data", 32'(bus.data_out), 32'h33);
    chk("hold_valid", 32'(bus.rd_valid), 32'd0);

    wr_word(10'h010, 8'h0F, 1'b1);
    rd_word(10'h010);
    chk("inj_data", 32'(bus.data_out), 32'h0F);
    idle();
    wr_word(10'h010, 8'h0F, 1'b0);
    rd_word(10'h010);
    chk("clean_par", 32'(bus.par_err), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      logic [ADDR_W-1:0] a;
      a = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 31));
      cyc(1'b0, ($urandom_range(0, 4) != 0), $urandom_range(0, 1) == 1, a,
          DATA_W'($urandom), ($urandom_range(0, 3) == 0));
    end

    wr_word(10'h3FF, 8'h55, 1'b0);
    rd_word(10'h3FF);
    chk("top_addr", 32'(bus.data_out), 32'h55);
    cyc(1'b1, 1'b1, 1'b0, 10'h3FF, '0, 1'b0);
    chk("rst_dout", 32'(bus.data_out), 32'h00);
    chk("rst_valid", 32'(bus.rd_valid), 32'd0);
    wait_clear();
    rd_word(10'h3FF);
    chk("top_cleared", 32'(bus.data_out), 32'h00);

    for (int i = 0; i < 500; i++) begin
      cyc(1'b0, ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
          ADDR_W'($urandom_range(0, 15)), DATA_W'($urandom), ($urandom_range(0, 1) == 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_param.md
SRAM_PARAM -- requirements
Module: sram_param

Interface
REQ-001 Parameter DATA_W, default 8: word width in bits.
REQ-002 Parameter ADDR_W, default 10: address width in bits; depth DEPTH = 2**ADDR_W words (default 1024).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cs  input  1  chip select; request present when high.
REQ-006 wr  input  1  1 = write request, 0 = read request; sampled only with cs.
REQ-007 addr  input  ADDR_W  word address.
REQ-008 data_in  input  DATA_W  write data.
REQ-009 inj_par_err  input  1  on an accepted write, store inverted parity (test hook).
REQ-010 req_ready  output  1  high when a request will be accepted this cycle.
REQ-011 busy  output  1  high while the clear sequence runs.
REQ-012 data_out  output  DATA_W  registered read data.
REQ-013 rd_valid  output  1  one-cycle pulse: data_out carries new read data.
REQ-014 par_err  output  1  one-cycle pulse with rd_valid on read parity mismatch.

Function
REQ-015 FSM states: CLEAR, RUN; encoding free.
REQ-016 CLEAR: write zero (and matching parity) to one address per cycle, counter running 0 to DEPTH-1; busy=1, req_ready=0.
REQ-017 CLEAR -> RUN on the edge that writes address DEPTH-1; total CLEAR duration exactly DEPTH cycles; busy falls and req_ready rises together.
REQ-018 RUN: req_ready=1 always; busy=0; RUN exits only on rst.
REQ-019 Accept = cs & req_ready at a rising edge; cs while req_ready=0 has no effect and is not queued.
REQ-020 Accepted write: mem[addr] <= data_in on that edge; data_out, rd_valid unchanged (rd_valid 0).
REQ-021 Accepted read: data_out <= mem[addr] and rd_valid <= 1 on that edge (latency 1 cycle); back-to-back reads give rd_valid high continuously.
REQ-022 rd_valid returns to 0 on any edge without an accepted read; data_out holds last read value until next accepted read.
REQ-023 Write to address A followed by read of A on the next cycle returns the new data.
REQ-024 One access per cycle (single port); wr, addr, data_in ignored when cs=0.
REQ-025 Address range is exactly DEPTH; no out-of-range case exists.

Reset
REQ-026 rst high at a rising edge: FSM -> CLEAR, clear counter -> 0, data_out -> 0, rd_valid -> 0, par_err -> 0, busy -> 1, req_ready -> 0.
REQ-027 rst during CLEAR or RUN abandons any in-progress activity; the clear restarts from address 0; no request is accepted in the reset cycle.
REQ-028 While rst is held, memory contents are not written; the clear begins on the first edge with rst low.

Configuration
REQ-029 Macro SRAM_PARITY_EN defined: each word stores DATA_W+1 bits (data plus even parity); a write stores parity of data_in, inverted if inj_par_err=1; an accepted read recomputes parity, and par_err pulses with rd_valid on mismatch.
REQ-030 SRAM_PARITY_EN undefined: no parity storage; inj_par_err ignored; par_err constant 0; all other behaviour identical.

Verification
REQ-031 Reset then idle: busy=1, req_ready=0 for exactly 1024 cycles after rst falls (defaults), then busy=0, req_ready=1; data_out=0, rd_valid=0 throughout.
REQ-032 After clear, write 8'hFC to addr 10'h030, read 10'h030 next cycle -> data_out=8'hFC, rd_valid=1 one cycle later; read 10'h03C -> data_out=8'h00 (cleared).
REQ-033 cs=1, wr=1, data_in=8'hAA, addr 10'h005 while busy=1 -> after clear, read 10'h005 returns 8'h00.
REQ-034 Write 8'h55 at 10'h3FF, assert rst for one cycle mid-run, wait for clear, read 10'h3FF -> 8'h00; rd_valid=0 and data_out=0 immediately after reset.
REQ-035 Reads of 10'h001, 10'h002, 10'h003 on consecutive cycles -> rd_valid high three consecutive cycles with the corresponding data; cs low next cycle -> rd_valid=0, data_out held.
REQ-036 With SRAM_PARITY_EN: write 8'h0F at 10'h010 with inj_par_err=1, read it -> data_out=8'h0F, par_err=1 for one cycle; rewrite with inj_par_err=0, read -> par_err=0; without the macro, par_err=0 in both cases.
